// File: rtl/tdc_hw_accum.sv
// rtl/tdc_hw_accum.sv - accumulates 2**LOG2_SAMPLES TDC hamming weights into sum/mean/min/max
// Optional: define TDC_ACCUM_MINMAX_EN to compile in min/max tracking.
module tdc_hw_accum #(
  parameter int N            = 64,
  parameter int LOG2_SAMPLES = 4,
  parameter int HW_W         = $clog2(N) + 1,
  parameter int SUM_W        = HW_W + LOG2_SAMPLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [HW_W-1:0]  hw_in,
  input  logic             hw_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] sum,
  output logic [HW_W-1:0]  mean,
  output logic [HW_W-1:0]  hw_min,
  output logic [HW_W-1:0]  hw_max,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [HW_W-1:0] N_HW = HW_W'(N);

  state_t                    state;
  state_t                    state_next;
  logic [SUM_W-1:0]          acc;
  logic [SUM_W-1:0]          acc_next;
  logic [LOG2_SAMPLES-1:0]   cnt;
  logic [HW_W-1:0]           hw_c;
  logic [SUM_W-1:0]          sum_q;
  logic [HW_W-1:0]           mean_q;
  logic                      out_valid_q;
  logic                      overrun_q;
  logic                      take;
  logic                      last;
  logic                      handshake;
  logic                      clear;

  always_comb begin
    hw_c      = (hw_in > N_HW) ? N_HW : hw_in;
    acc_next  = acc + SUM_W'(hw_c);
    take      = en && (state == ACCUM) && hw_valid && !start;
    last      = take && (cnt == '1);
    handshake = (state == DONE) && out_valid_q && out_ready;
    // A start is only honoured where it cannot tear an unread result.
    clear     = en && start && ((state == IDLE) || (state == ACCUM) || handshake);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (en) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACCUM;
      ACCUM: begin
        if (start)     state_next = ACCUM;
        else if (last) state_next = DONE;
      end
      DONE:    if (handshake) state_next = start ? ACCUM : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      cnt         <= '0;
      sum_q       <= '0;
      mean_q      <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (en) begin
      if (clear) begin
        acc       <= '0;
        cnt       <= '0;
        overrun_q <= 1'b0;
      end else begin
        if (take) begin
          acc <= acc_next;
          cnt <= cnt + LOG2_SAMPLES'(1);
        end
        if ((state == DONE) && hw_valid) overrun_q <= 1'b1;
      end
      if (last) begin
        sum_q       <= acc_next;
        mean_q      <= acc_next[SUM_W-1:LOG2_SAMPLES];
        out_valid_q <= 1'b1;
      end else if (handshake) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef TDC_ACCUM_MINMAX_EN
  logic [HW_W-1:0] run_min;
  logic [HW_W-1:0] run_max;
  logic [HW_W-1:0] min_next;
  logic [HW_W-1:0] max_next;
  logic [HW_W-1:0] min_q;
  logic [HW_W-1:0] max_q;

  always_comb begin
    min_next = (hw_c < run_min) ? hw_c : run_min;
    max_next = (hw_c > run_max) ? hw_c : run_max;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_min <= '1;
      run_max <= '0;
      min_q   <= '0;
      max_q   <= '0;
    end else if (en) begin
      if (clear) begin
        run_min <= '1;
        run_max <= '0;
      end else if (take) begin
        run_min <= min_next;
        run_max <= max_next;
      end
      if (last) begin
        min_q <= min_next;
        max_q <= max_next;
      end
    end
  end

  assign hw_min = min_q;
  assign hw_max = max_q;
`else
  assign hw_min = '0;
  assign hw_max = '0;
`endif

  assign sum       = sum_q;
  assign mean      = mean_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign busy      = (state == ACCUM);

endmodule

// File: tb/tb_tdc_hw_accum.sv
// tb/tb_tdc_hw_accum.sv - directed self-checking bench for tdc_hw_accum
// Min/max expectations follow TDC_ACCUM_MINMAX_EN.
module tb_tdc_hw_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        start;
  logic [6:0]  hw_in;
  logic        hw_valid;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] sum;
  logic [6:0]  mean;
  logic [6:0]  hw_min;
  logic [6:0]  hw_max;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tdc_hw_accum dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .start     (start),
    .hw_in     (hw_in),
    .hw_valid  (hw_valid),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .mean      (mean),
    .hw_min    (hw_min),
    .hw_max    (hw_max),
    .busy      (busy),
    .overrun   (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [6:0] v);
    hw_in    = v;
    hw_valid = 1'b1;
    tick();
    hw_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic check_minmax(input string tag, input logic [6:0] mn, input logic [6:0] mx);
`ifdef TDC_ACCUM_MINMAX_EN
    check({tag, "_min"}, 32'(hw_min), 32'(mn));
    check({tag, "_max"}, 32'(hw_max), 32'(mx));
`else
    check({tag, "_min"}, 32'(hw_min), 32'(0 * mn));
    check({tag, "_max"}, 32'(hw_max), 32'(0 * mx));
`endif
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0; hw_in = '0; hw_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_sum", 32'(sum), 0);
    check("rst_mean", 32'(mean), 0);
    check_minmax("rst", 7'd0, 7'd0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun), 0);

    // constant 32; sample driven in the start cycle must be ignored
    hw_in = 7'd99; hw_valid = 1'b1;
    pulse_start();
    hw_valid = 1'b0;
    check("s1_busy", 32'(busy), 1);
    for (int i = 0; i < 15; i++) sample(7'd32);
    check("s1_early_valid", 32'(out_valid), 0);
    sample(7'd32);
    check("s1_out_valid", 32'(out_valid), 1);
    check("s1_sum", 32'(sum), 512);
    check("s1_mean", 32'(mean), 32);
    check_minmax("s1", 7'd32, 7'd32);
    check("s1_busy_done", 32'(busy), 0);
    handshake();
    check("s1_hs_valid", 32'(out_valid), 0);

    // ramp 0..15
    pulse_start();
    for (int i = 0; i < 16; i++) sample(7'(i));
    check("s2_sum", 32'(sum), 120);
    check("s2_mean", 32'(mean), 7);
    check_minmax("s2", 7'd0, 7'd15);
    handshake();
    check("s2_busy_idle", 32'(busy), 0);
    check("s2_hold_sum", 32'(sum), 120);

    // clamp above N
    pulse_start();
    for (int i = 0; i < 16; i++) sample(7'd100);
    check("s3_sum", 32'(sum), 1024);
    check("s3_mean", 32'(mean), 64);
    check_minmax("s3", 7'd64, 7'd64);

    // stall in DONE with a stray sample
    for (int i = 0; i < 10; i++) begin
      hw_valid = (i == 3);
      hw_in    = 7'd5;
      tick();
    end
    hw_valid = 1'b0;
    check("s4_valid_held", 32'(out_valid), 1);
    check("s4_sum_held", 32'(sum), 1024);
    check("s4_overrun", 32'(overrun), 1);
    out_ready = 1'b1;
    pulse_start();
    out_ready = 1'b0;
    check("s4_overrun_clr", 32'(overrun), 0);
    check("s4_direct_accum", 32'(busy), 1);
    check("s4_valid_low", 32'(out_valid), 0);
    check("s4_sum_kept", 32'(sum), 1024);

    // abort after 5 samples, restart
    for (int i = 0; i < 5; i++) sample(7'd7);
    pulse_start();
    for (int i = 0; i < 16; i++) sample(7'd10);
    check("s5_valid", 32'(out_valid), 1);
    check("s5_sum", 32'(sum), 160);
    check("s5_mean", 32'(mean), 10);
    check_minmax("s5", 7'd10, 7'd10);
    handshake();

    // en low mid-accumulation freezes counting
    pulse_start();
    for (int i = 0; i < 8; i++) sample(7'd5);
    en = 1'b0;
    for (int i = 0; i < 4; i++) sample(7'd50);
    en = 1'b1;
    check("s6_busy_frozen", 32'(busy), 1);
    for (int i = 0; i < 7; i++) sample(7'd5);
    check("s6_not_early", 32'(out_valid), 0);
    sample(7'd5);
    check("s6_valid", 32'(out_valid), 1);
    check("s6_sum", 32'(sum), 80);
    check("s6_mean", 32'(mean), 5);

    // reset while DONE discards result
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s7_valid", 32'(out_valid), 0);
    check("s7_sum", 32'(sum), 0);
    check("s7_mean", 32'(mean), 0);
    check_minmax("s7", 7'd0, 7'd0);
    check("s7_busy", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
